// File: rtl/hermes_input_buffer_pkg.sv
// Shared constants and FSM encoding for the Hermes per-port input buffer.
// Flit width, default depth and the is_sending decode live here.
package hermes_input_buffer_pkg;

    localparam int TAM_FLIT     = 16;
    localparam int BUFFER_DEPTH = 16;

    typedef enum logic [2:0] {
        IB_IDLE,
        IB_REQ,
        IB_HDR,
        IB_SIZE,
        IB_PAYLOAD
    } ib_state_t;

    function automatic logic is_sending(ib_state_t s);
        return (s == IB_HDR) || (s == IB_SIZE) || (s == IB_PAYLOAD);
    endfunction

endpackage

// File: rtl/hermes_input_buffer_fifo_ring.sv
// Circular flit storage with wrap-around pointers and an occupancy count.
// The storage array is deliberately left unreset.
module fifo_ring #(
    parameter int W     = 16,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          wr_en_i,
    input  logic          rd_en_i,
    input  logic [W-1:0]  din_i,
    output logic [W-1:0]  dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_ok, rd_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign wr_ok = wr_en_i & ~full_o;
    assign rd_ok = rd_en_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        if (wr_ok && !rd_ok) count_d = count_q + 1'b1;
        if (!wr_ok && rd_ok) count_d = count_q - 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/hermes_input_buffer.sv
// Hermes router input port: credit-based FIFO plus routing request and
// packet streaming FSM; o_sender's falling edge frees the output.
module hermes_input_buffer
    import hermes_input_buffer_pkg::*;
#(
    parameter int FLIT_W = TAM_FLIT,
    parameter int DEPTH  = BUFFER_DEPTH
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rx,
    input  logic [FLIT_W-1:0] i_data_in,
    output logic              o_credit,
    output logic              o_h,
    input  logic              i_ack_h,
    output logic [FLIT_W-1:0] o_data,
    output logic              o_data_av,
    input  logic              i_data_ack,
    output logic              o_sender
);

    localparam int CW = $clog2(DEPTH) + 1;

    ib_state_t         state_q, state_d;
    logic [FLIT_W-1:0] rem_q, rem_d;
    logic              h_q, sender_q;
    logic              full, empty;
    logic [CW-1:0]     count;
    logic              wr, rd;

    fifo_ring #(
        .W     (FLIT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .wr_en_i (wr),
        .rd_en_i (rd),
        .din_i   (i_data_in),
        .dout_o  (o_data),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    // Outputs are forced low combinationally while reset is held.
    assign o_credit  = i_rst & ~full;
    assign o_h       = i_rst & h_q;
    assign o_sender  = i_rst & sender_q;
    assign o_data_av = i_rst & sender_q & ~empty;

    assign wr = i_rx & o_credit;
    assign rd = o_data_av & i_data_ack;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        unique case (state_q)
            IB_IDLE: begin
                if (count != '0) state_d = IB_REQ;
            end
            IB_REQ: begin
                if (i_ack_h) state_d = IB_HDR;
            end
            IB_HDR: begin
                if (rd) state_d = IB_SIZE;
            end
            IB_SIZE: begin
                if (rd) begin
                    rem_d   = o_data;
                    state_d = (o_data == '0) ? IB_IDLE : IB_PAYLOAD;
                end
            end
            IB_PAYLOAD: begin
                if (rd) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == FLIT_W'(1)) state_d = IB_IDLE;
                end
            end
            default: state_d = IB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q  <= IB_IDLE;
            rem_q    <= '0;
            h_q      <= 1'b0;
            sender_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            h_q      <= (state_d == IB_REQ);
            sender_q <= is_sending(state_d);
        end
    end

endmodule

// File: doc/hermes_input_buffer.md
Name: hermes_input_buffer

Overview:
Per-port input buffer on the receiving side of the router's header-request handshake with the switch control.
- Accepts flits from a neighbour router through a credit-based link and stores them in a circular FIFO.
- When a header flit reaches the FIFO head, raises a routing request (o_h) and waits for the grant (i_ack_h).
- After the grant, streams header, size and payload flits to the crossbar while asserting o_sender. The falling edge of o_sender is what tells the switch control to free the allocated output.
- One instance per router port (NPORT instances per router).

Parameters:
FLIT_W, `TAM_FLIT, flit width in bits; also the width of the size field.
DEPTH, 16, FIFO depth in flits; must be a power of two and at least 2.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-low
i_rx  in  1  upstream flit valid
i_data_in  in  FLIT_W  upstream flit
o_credit  out  1  buffer can accept a flit this cycle
o_h  out  1  routing request to switch control
i_ack_h  in  1  routing grant from switch control
o_data  out  FLIT_W  head-of-FIFO flit; drives both the header input of switch control and the crossbar
o_data_av  out  1  o_data is a valid flit for the crossbar
i_data_ack  in  1  crossbar/downstream consumed o_data
o_sender  out  1  packet in transit through this port

Behaviour:
Packet format: flit 0 = header (destination), flit 1 = size N (unsigned, FLIT_W bits), then N payload flits.

FIFO:
- write = i_rx & o_credit
- read = o_data_av & i_data_ack
- o_credit = i_rst & (count != DEPTH). Based on count before the read, so no write into a full FIFO even when a read happens in the same cycle.
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits.
- Simultaneous read and write (not full): count unchanged, both pointers advance.
- o_data = mem[rd_ptr], combinational. Don't-care when empty.
- Memory is not reset.

FSM, registered state:
- S_IDLE: o_h=0, o_sender=0. If count!=0 -> S_REQ.
- S_REQ: o_h=1. i_ack_h sampled high -> S_HDR; otherwise stay. o_h stays high until i_ack_h is sampled.
- S_HDR: o_sender=1. On read -> S_SIZE.
- S_SIZE: o_sender=1. On read, load remaining <= o_data. If o_data==0 -> S_IDLE, else -> S_PAYLOAD.
- S_PAYLOAD: o_sender=1. On read, remaining <= remaining-1. If remaining==1 on that read -> S_IDLE.

Output decode:
- o_h = (state==S_REQ)
- o_sender = state in {S_HDR, S_SIZE, S_PAYLOAD}
- o_data_av = o_sender & (count!=0)
- i_data_ack is ignored while o_data_av=0.

Timing rules:
- Latency: a flit written at edge k is visible on o_data at k+1. From an empty buffer, o_h asserts one cycle after the header write.
- S_IDLE always lasts at least 1 cycle, so o_sender is low for at least 1 cycle between packets. The switch control relies on this edge.
- i_ack_h asserted outside S_REQ is ignored.

Reset (i_rst=0 at an edge, including mid-packet):
- state <= S_IDLE; rd_ptr, wr_ptr, count, remaining <= 0.
- While i_rst=0: o_h=0, o_sender=0, o_data_av=0, o_credit=0.
- After reset: o_credit=1.
- Any partial packet is discarded.

Decomposition:
- defines.vh: `TAM_FLIT; new constants for the FSM state encodings (IB_IDLE, IB_REQ, IB_HDR, IB_SIZE, IB_PAYLOAD) and `BUFFER_DEPTH (default 16).
- One sub-module, fifo_ring: circular storage with pointers and count. It exposes wr_en, rd_en, din, dout, full, empty, count.
- The FSM and size counter stay in hermes_input_buffer.

Test Plan:
1. DEPTH=16. Write packet 0x0011, 0x0003, 0xA1, 0xA2, 0xA3; ack_h 3 cycles after o_h rises; i_data_ack=1 throughout -> o_h high exactly until ack sampled. o_data sequence is 0x0011, 0x0003, 0xA1, 0xA2, 0xA3. o_sender falls the cycle after 0xA3 is read.
2. DEPTH=4, i_rx=1 for 6 flits, no ack_h -> o_credit low after the 4th write; flits 5 and 6 are held upstream. After the grant and one read, o_credit returns high the next cycle and count stays ≤4.
3. Zero payload: 0x0022, 0x0000 -> o_sender high for exactly the two flit reads, then low. FSM goes S_SIZE -> S_IDLE.
4. Back-to-back: two 1-payload packets already queued -> o_sender low for at least 1 cycle between packets, and the second o_h rises only after that low cycle.
5. Wrap-around: DEPTH=4, packet with N=20 and continuous rx/ack -> all 22 flits appear in order; count never exceeds 4.
6. Reset mid-packet: i_rst=0 for 1 cycle after 2 of 5 payload flits are read -> all outputs 0 during reset; afterwards o_credit=1, count=0, and a new packet is processed normally from its header.
